mealy_state_seq: RTL and testbench

//  State register and next-state logic for the 4-state Mealy machine (Sa/Sb/Sc/Sd).

---
 rtl/mealy_pkg.sv | 26 ++
 rtl/sd_dwell_timer.sv | 33 +++
 rtl/mealy_state_seq.sv | 92 +++++++++
 tb/tb_mealy_state_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mealy_pkg.sv
// Shared state encoding for the 4-state Mealy sequencer and its output decoder.
// The accept-driven transition rule lives here so both sides agree on it.
package mealy_pkg;

    typedef enum logic [1:0] {
        Sa = 2'd0,
        Sb = 2'd1,
        Sc = 2'd2,
        Sd = 2'd3
    } state_t;

    // Next state taken on an accepted input bit. Sd never accepts; it holds here
    // and the dwell timer alone moves the machine out of it.
    function automatic state_t next_on_accept(input state_t cur, input logic bit_in);
        state_t nxt;
        nxt = cur;
        case (cur)
            Sa:      nxt = bit_in ? Sc : Sb;
            Sb:      nxt = bit_in ? Sd : Sc;
            Sc:      nxt = bit_in ? Sd : Sa;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sd_dwell_timer.sv
// Counts the cycles spent in Sd; done is high during the last Sd cycle so the
// sequencer can schedule the return to Sa on the following edge.
module sd_dwell_timer #(
    parameter int SD_DWELL = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic run,
    output logic done
);

    localparam int CW = (SD_DWELL > 1) ? $clog2(SD_DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(SD_DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign done   = run & w_last;

    // start loads 0 on the entry edge, so the first Sd cycle sees count 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mealy_state_seq.sv
// State register and next-state logic for the Sa/Sb/Sc/Sd Mealy machine, with a
// valid/ready input handshake, a fixed Sd dwell and a saturating step counter.
module mealy_state_seq
    import mealy_pkg::*;
#(
    parameter int SD_DWELL = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count,
    output logic             step_sat,
    output logic             sd_exit
);

    // Handshake: a bit is consumed on a rising edge where in_valid and in_ready
    // are both high. in_ready depends only on the state register, never on in_valid.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_step_count;
    logic [CNT_W-1:0] w_step_next;
    logic             r_step_sat;
    logic             r_sd_exit;
    logic             w_sd_exit_next;
    logic             w_accept;
    logic             w_dwell_start;
    logic             w_dwell_run;
    logic             w_dwell_done;

    assign in_ready    = (r_state != Sd);
    assign w_accept    = in_valid & in_ready;
    assign w_dwell_run = (r_state == Sd);

    sd_dwell_timer #(
        .SD_DWELL(SD_DWELL)
    ) u_dwell (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (w_dwell_start),
        .run    (w_dwell_run),
        .done   (w_dwell_done)
    );

    always_comb begin
        w_next_state   = r_state;
        w_sd_exit_next = 1'b0;
        w_dwell_start  = 1'b0;
        if (r_state == Sd) begin
            if (w_dwell_done) begin
                w_next_state   = Sa;
                w_sd_exit_next = 1'b1;
            end
        end else if (w_accept) begin
            w_next_state  = next_on_accept(r_state, in_bit);
            w_dwell_start = (w_next_state == Sd);
        end
    end

    always_comb begin
        w_step_next = r_step_count;
        if (w_accept && (r_step_count != CNT_MAX)) begin
            w_step_next = r_step_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= Sa;
            r_step_count <= '0;
            r_step_sat   <= 1'b0;
            r_sd_exit    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_step_count <= w_step_next;
            r_step_sat   <= (w_step_next == CNT_MAX);
            r_sd_exit    <= w_sd_exit_next;
        end
    end

    assign state      = r_state;
    assign step_count = r_step_count;
    assign step_sat   = r_step_sat;
    assign sd_exit    = r_sd_exit;

endmodule

// File: tb/tb_mealy_state_seq.sv
// Bench for mealy_state_seq: two instances (default and SD_DWELL=1/CNT_W=2) share
// one input stream and are checked every cycle against a table-driven model.
module tb_mealy_state_seq;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid;
    logic in_bit;

    logic       ready_a, ready_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sat_a, sat_b;
    logic       exit_a, exit_b;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mealy_state_seq #(.SD_DWELL(4), .CNT_W(8)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (ready_a),
        .state     (state_a),
        .step_count(cnt_a),
        .step_sat  (sat_a),
        .sd_exit   (exit_a)
    );

    mealy_state_seq #(.SD_DWELL(1), .CNT_W(2)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (ready_b),
        .state     (state_b),
        .step_count(cnt_b),
        .step_sat  (sat_b),
        .sd_exit   (exit_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States as integers 0..3 (3 = the dwell state); next state looked up by [state][bit].
    int nxt_tbl [3][2] = '{'{1, 2}, '{2, 3}, '{0, 3}};
    int dwell   [2]    = '{4, 1};
    int cmax    [2]    = '{255, 3};
    int m_state [2];
    int m_left  [2];
    int m_cnt   [2];
    int m_exit  [2];

    function automatic int act_state(input int i);
        return (i == 0) ? int'(state_a) : int'(state_b);
    endfunction
    function automatic int act_ready(input int i);
        return (i == 0) ? int'(ready_a) : int'(ready_b);
    endfunction
    function automatic int act_cnt(input int i);
        return (i == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction
    function automatic int act_sat(input int i);
        return (i == 0) ? int'(sat_a) : int'(sat_b);
    endfunction
    function automatic int act_exit(input int i);
        return (i == 0) ? int'(exit_a) : int'(exit_b);
    endfunction

    // ---------------- compare process (negedge, inputs stable) ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_state[i] = 0;
                m_left[i]  = 0;
                m_cnt[i]   = 0;
                m_exit[i]  = 0;
            end
            chk($sformatf("model state[%0d]", i), act_state(i), m_state[i]);
            chk($sformatf("model in_ready[%0d]", i), act_ready(i), (m_state[i] != 3) ? 1 : 0);
            chk($sformatf("model step_count[%0d]", i), act_cnt(i), m_cnt[i]);
            chk($sformatf("model step_sat[%0d]", i), act_sat(i), (m_cnt[i] == cmax[i]) ? 1 : 0);
            chk($sformatf("model sd_exit[%0d]", i), act_exit(i), m_exit[i]);
            if (reset_n) begin
                m_exit[i] = 0;
                if (m_state[i] == 3) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_state[i] = 0;
                        m_exit[i]  = 1;
                    end
                end else if (in_valid) begin
                    m_state[i] = nxt_tbl[m_state[i]][in_bit ? 1 : 0];
                    if (m_state[i] == 3) m_left[i] = dwell[i];
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        logic [1:0] s_hold;
        logic [7:0] c_hold;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset state", int'(state_a), 0);
        chk("reset count", int'(cnt_a), 0);
        reset_n = 1'b1;

        // Accept 0,0,0: Sb, Sc, Sa
        step(1'b1, 1'b0);
        chk("t1 state Sb", int'(state_a), 1);
        step(1'b1, 1'b0);
        chk("t1 state Sc", int'(state_a), 2);
        step(1'b1, 1'b0);
        chk("t1 state Sa", int'(state_a), 0);
        chk("t1 count", int'(cnt_a), 3);
        chk("t4 small count", int'(cnt_b), 3);
        chk("t4 small sat", int'(sat_b), 1);

        // Accept 1,1: Sc then Sd, then hold valid in Sd
        step(1'b1, 1'b1);
        chk("t2 state Sc", int'(state_a), 2);
        step(1'b1, 1'b1);
        chk("t2 state Sd", int'(state_a), 3);
        in_valid = 1'b1;
        in_bit   = 1'b0;
        n = 0;
        while (ready_a == 1'b0 && n < 20) begin
            n++;
            @(posedge clk);
            #2;
        end
        chk("t2 ready low cycles", n, 4);
        chk("t2 sd_exit pulse", int'(exit_a), 1);
        chk("t2 back to Sa", int'(state_a), 0);
        chk("t3 count held in Sd", int'(cnt_a), 5);
        step(1'b0, 1'b0);
        chk("t2 sd_exit one cycle", int'(exit_a), 0);
        chk("t4 small no wrap", int'(cnt_b), 3);

        // Reset mid-dwell at dwell count 2
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t5 in Sd", int'(state_a), 3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5 async state", int'(state_a), 0);
        chk("t5 async count", int'(cnt_a), 0);
        chk("t5 async exit", int'(exit_a), 0);
        repeat (2) @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        reset_n  = 1'b1;
        step(1'b1, 1'b1);
        chk("t5 first accept after release", int'(state_a), 2);
        chk("t5 count after release", int'(cnt_a), 1);

        // Idle with toggling in_bit
        s_hold = state_a;
        c_hold = cnt_a;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, k[0]);
            chk("t6 idle state", int'(state_a), int'(s_hold));
            chk("t6 idle count", int'(cnt_a), int'(c_hold));
        end

        // Random phase with occasional async reset
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit   = $urandom_range(0, 1) != 0;
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
